// File: rtl/d_delay_line_if.sv
// Bus bundle for d_delay_line: control/data inputs, output stage, tap and occupancy count.
interface d_delay_line_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          en;
  logic          flush;
  logic          in_valid;
  logic [N-1:0]  in_d;
  logic [SW-1:0] tap_sel;
  logic [N-1:0]  out_q;
  logic          out_valid;
  logic [N-1:0]  tap_q;
  logic          tap_valid;
  logic [CW-1:0] count;

  modport master (
    output en, flush, in_valid, in_d, tap_sel,
    input  out_q, out_valid, tap_q, tap_valid, count
  );

  modport slave (
    input  en, flush, in_valid, in_d, tap_sel,
    output out_q, out_valid, tap_q, tap_valid, count
  );
endinterface

// File: rtl/d_delay_line.sv
// DEPTH-stage shift register of (data, valid) words with enable, synchronous flush,
// a selectable tap and a registered count of occupied stages.
module d_delay_line #(
  parameter int unsigned N             = 4,
  parameter int unsigned DEPTH         = 4,
  parameter logic [N-1:0] RESET_VAL    = '0
) (
  input  logic           clk,
  input  logic           reset,
  d_delay_line_if.slave  bus
);
  localparam int unsigned SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][N-1:0] data_q, data_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [CW-1:0]           count_q, count_d;
  logic [N-1:0]            tap_data;
  logic                    tap_vld;

  // Next-state: flush beats enable; enable shifts everything one stage deeper.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (bus.flush) begin
      data_d  = {DEPTH{RESET_VAL}};
      valid_d = '0;
    end else if (bus.en) begin
      data_d[0]  = bus.in_d;
      valid_d[0] = bus.in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  // Count tracks the post-edge occupancy, so it is the popcount of the next valid vector.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= {DEPTH{RESET_VAL}};
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Out-of-range selects (and every select when DEPTH=1) fall back to the last stage.
  always_comb begin
    tap_data = data_q[DEPTH-1];
    tap_vld  = valid_q[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (SW'(i) == bus.tap_sel) begin
        tap_data = data_q[i];
        tap_vld  = valid_q[i];
      end
    end
  end

  assign bus.out_q     = data_q[DEPTH-1];
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.tap_q     = tap_data;
  assign bus.tap_valid = tap_vld;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_d_delay_line.sv
// Directed bench for d_delay_line (N=4, DEPTH=4): fill, stall, flush, bubbles, async reset, taps.
module tb_d_delay_line;
  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  d_delay_line_if #(.N(N), .DEPTH(DEPTH)) bus ();

  d_delay_line #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic en, input logic fl, input logic vld, input logic [3:0] d);
    bus.en       = en;
    bus.flush    = fl;
    bus.in_valid = vld;
    bus.in_d     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] q, input logic v, input logic [2:0] c);
    chk({tag, ".out_q"}, 32'(bus.out_q), 32'(q));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
  endtask

  task automatic chk_tap(input string tag, input logic [1:0] sel, input logic [3:0] q, input logic v);
    bus.tap_sel = sel;
    #1;
    chk({tag, ".tap_q"}, 32'(bus.tap_q), 32'(q));
    chk({tag, ".tap_valid"}, 32'(bus.tap_valid), 32'(v));
  endtask

  // Fill 1,2,3,4 from an empty line: count steps 1..4, word 1 lands on out_q at edge 4.
  task automatic fill(input string tag);
    step(1'b1, 1'b0, 1'b1, 4'd1); chk_out({tag, ".e1"}, 4'd0, 1'b0, 3'd1);
    step(1'b1, 1'b0, 1'b1, 4'd2); chk_out({tag, ".e2"}, 4'd0, 1'b0, 3'd2);
    step(1'b1, 1'b0, 1'b1, 4'd3); chk_out({tag, ".e3"}, 4'd0, 1'b0, 3'd3);
    step(1'b1, 1'b0, 1'b1, 4'd4); chk_out({tag, ".e4"}, 4'd1, 1'b1, 3'd4);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_d     = '0;
    bus.tap_sel  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 4'd0, 1'b0, 3'd0);
    #3 reset = 1'b0;

    // Fill, then inspect every stage through the tap
    fill("fill");
    chk_tap("tap2", 2'd2, 4'd2, 1'b1);
    chk_tap("tap0", 2'd0, 4'd4, 1'b1);
    chk_tap("tap1", 2'd1, 4'd3, 1'b1);
    chk_tap("tap3", 2'd3, 4'd1, 1'b1);

    // Stall: en=0 holds everything despite in_d=F
    step(1'b0, 1'b0, 1'b1, 4'hF); chk_out("stall1", 4'd1, 1'b1, 3'd4);
    step(1'b0, 1'b0, 1'b1, 4'hF); chk_out("stall2", 4'd1, 1'b1, 3'd4);
    step(1'b0, 1'b0, 1'b1, 4'hF); chk_out("stall3", 4'd1, 1'b1, 3'd4);
    chk_tap("stall_tap0", 2'd0, 4'd4, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4'hF); chk_out("resume", 4'd2, 1'b1, 3'd4);
    chk_tap("resume_tap0", 2'd0, 4'hF, 1'b1);

    // Flush with en=1: incoming 9 discarded, everything cleared
    step(1'b1, 1'b1, 1'b1, 4'd9); chk_out("flush", 4'd0, 1'b0, 3'd0);
    chk_tap("flush_tap0", 2'd0, 4'd0, 1'b0);
    chk_tap("flush_tap3", 2'd3, 4'd0, 1'b0);

    // Bubbles: valid pattern 1,0,1,0 on 5,6,7,8 then drain with invalid zeros
    step(1'b1, 1'b0, 1'b1, 4'd5); chk_out("bub1", 4'd0, 1'b0, 3'd1);
    step(1'b1, 1'b0, 1'b0, 4'd6); chk_out("bub2", 4'd0, 1'b0, 3'd1);
    step(1'b1, 1'b0, 1'b1, 4'd7); chk_out("bub3", 4'd0, 1'b0, 3'd2);
    step(1'b1, 1'b0, 1'b0, 4'd8); chk_out("bub4", 4'd5, 1'b1, 3'd2);
    chk_tap("bub_tap1", 2'd1, 4'd7, 1'b1);
    chk_tap("bub_tap2", 2'd2, 4'd6, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0); chk_out("bub5", 4'd6, 1'b0, 3'd1);
    step(1'b1, 1'b0, 1'b0, 4'd0); chk_out("bub6", 4'd7, 1'b1, 3'd1);
    step(1'b1, 1'b0, 1'b0, 4'd0); chk_out("bub7", 4'd8, 1'b0, 3'd0);

    // Flush with en=0 still clears a partially filled line
    step(1'b1, 1'b0, 1'b1, 4'd3); chk_out("pre_fl", 4'd0, 1'b0, 3'd1);
    step(1'b0, 1'b1, 1'b1, 4'd3); chk_out("flush_en0", 4'd0, 1'b0, 3'd0);

    // Async reset mid-stream, between edges
    fill("refill");
    step(1'b1, 1'b0, 1'b1, 4'd5); chk_out("pre_rst", 4'd2, 1'b1, 3'd4);
    #2 reset = 1'b1;
    #1;
    chk_out("async_rst", 4'd0, 1'b0, 3'd0);
    chk_tap("async_rst_tap0", 2'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'hA); chk_out("rst_hold1", 4'd0, 1'b0, 3'd0);
    step(1'b1, 1'b1, 1'b1, 4'hA); chk_out("rst_hold2", 4'd0, 1'b0, 3'd0);
    #3 reset = 1'b0;
    fill("post_rst");
    chk_tap("post_rst_tap2", 2'd2, 4'd2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/d_delay_line.md
D_DELAY_LINE -- requirements
Module: d_delay_line

Interface
REQ-001 The block SHALL have parameter N, default 4, data width in bits (N >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of register stages (DEPTH >= 1).
REQ-003 The block SHALL have parameter RESET_VAL, default all-zero N-bit, the data value loaded by reset and flush.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port en, input, 1, shift enable.
REQ-007 The block SHALL have port flush, input, 1, synchronous clear of all stages.
REQ-008 The block SHALL have port in_valid, input, 1, qualifier for in_d.
REQ-009 The block SHALL have port in_d, input, N, data into stage 0.
REQ-010 The block SHALL have port tap_sel, input, SW = max(1, clog2(DEPTH)), selects the stage driven on tap_q.
REQ-011 The block SHALL have port out_q, output, N, data of stage DEPTH-1.
REQ-012 The block SHALL have port out_valid, output, 1, valid bit of stage DEPTH-1.
REQ-013 The block SHALL have port tap_q, output, N, data of stage tap_sel.
REQ-014 The block SHALL have port tap_valid, output, 1, valid bit of stage tap_sel.
REQ-015 The block SHALL have port count, output, clog2(DEPTH+1), number of stages whose valid bit is set.

Function
REQ-016 Each stage i SHALL hold an N-bit data register and a 1-bit valid register.
REQ-017 On a rising clk edge with flush=0 and en=1: stage 0 SHALL load in_d and in_valid, and stage i SHALL load stage i-1 for i = 1..DEPTH-1.
REQ-018 On a rising clk edge with flush=0 and en=0: all stages SHALL hold their value.
REQ-019 On a rising clk edge with flush=1: all data SHALL load RESET_VAL and all valid bits SHALL clear, regardless of en; a word presented in that cycle is discarded.
REQ-020 Latency: with en held at 1, a word sampled at edge k SHALL appear on out_q and out_valid after edge k+DEPTH-1, i.e. DEPTH edges including the sampling edge.
REQ-021 Data SHALL shift regardless of in_valid; in_valid=0 marks a bubble, which propagates like any other word.
REQ-022 out_q and out_valid SHALL be driven directly from stage DEPTH-1 registers, with no combinational path from inputs.
REQ-023 tap_q and tap_valid SHALL be combinational selects of the registered stages. If tap_sel >= DEPTH, they SHALL return stage DEPTH-1.
REQ-024 count SHALL be a register updated on the same edge as the stages.
- It SHALL equal the popcount of the post-edge valid bits.
- Range is 0..DEPTH; it never wraps.
REQ-025 With DEPTH=1, out_q and tap_q SHALL both show stage 0, and tap_sel SHALL be ignored.

Reset
REQ-026 While reset=1, and immediately on its assertion (asynchronous, mid-operation included): all data registers SHALL be RESET_VAL, all valid bits 0, and count 0.
REQ-027 This reset SHALL hold regardless of clk, en, or flush.
REQ-028 On the first rising clk edge after reset deasserts, the block SHALL operate per REQ-017..019.

Verification
REQ-029 Bench SHALL use N=4 and DEPTH=4 and cover the following scenarios:
- Fill: with en=1 and in_valid=1, drive in_d 1,2,3,4 on consecutive edges -> out_q=1 and out_valid=1 after the 4th edge; count steps 1,2,3,4; tap_sel=2 shows tap_q=2.
- Stall: after fill, en=0 for 3 edges with in_d=F -> out_q stays 1, count stays 4; with en=1 again, the next edge gives out_q=2.
- Bubble: drive in_valid pattern 1,0,1,0 with in_d=5,6,7,8 -> out_valid sequence 1,0,1,0 after latency; count never exceeds 2.
- Flush priority: with the line full, assert flush=1 and en=1 with in_d=9 -> after the edge out_valid=0, out_q=0, count=0; 9 never appears.
- Async reset: assert reset between clk edges mid-stream -> out_q=0, out_valid=0, count=0 before the next edge; after deassert, the fill scenario repeats correctly.
- Tap range: tap_sel=0..3 each match the expected stage contents.
